// File: rtl/rv_mc_loader_pkg.sv
// rv_mc_loader_pkg: shared types for the rv_mc boot loader.
// Loader FSM state encoding and err_code values.
package rv_mc_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERROR
  } ld_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CSUM    = 2'd3;

endpackage

// File: rtl/rv_mc_byte_packer.sv
// rv_mc_byte_packer: packs 4 bytes into a little-endian word.
// Ports: clk, reset (sync, active-low), push/din in,
//   consume clears; word out, word_full after 4 pushes,
//   last when one more push fills the word.
module rv_mc_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [7:0]  din,
  input  logic        consume,
  output logic [31:0] word,
  output logic        word_full,
  output logic        last
);

  logic [2:0] cnt;

  assign word_full = (cnt == 3'd4);
  assign last      = (cnt == 3'd3);

  // Bytes enter at the top, so the first byte ends in [7:0].
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt  <= 3'd0;
      word <= 32'd0;
    end else if (consume) begin
      cnt  <= 3'd0;
      word <= 32'd0;
    end else if (push && !word_full) begin
      cnt  <= cnt + 3'd1;
      word <= {din, word[31:8]};
    end
  end

endmodule

// File: rtl/rv_mc_boot_loader.sv
// rv_mc_boot_loader: streams a program image into the rv_mc RAM and
// holds the core in reset until the image is complete.
// Ports: clk, reset (sync, active-low); s_valid/s_data/s_ready byte
//   stream; load_req re-arm; mem_we/mem_addr/mem_wdata RAM write;
//   core_rst, busy, done, error, err_code, words_loaded status.
// Build option: LOADER_CHECKSUM_EN adds a trailing checksum byte.
module rv_mc_boot_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MAX_WORDS   = 1024,
  parameter int          TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  input  logic        load_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] words_loaded
);

  import rv_mc_loader_pkg::*;

`ifdef LOADER_CHECKSUM_EN
  localparam ld_state_t FIN_STATE = CHK;
`else
  localparam ld_state_t FIN_STATE = DONE;
`endif

  ld_state_t   state;
  ld_state_t   state_n;
  logic [1:0]  err_q;
  logic [1:0]  err_n;
  logic [15:0] n_words;
  logic [15:0] idx;
  logic [15:0] wl_q;
  logic [31:0] tcnt;
  logic [15:0] hdr;
  logic        accept;
  logic        tout;
  logic        waiting;
  logic        pk_push;
  logic        pk_consume;
  logic        pk_full;
  logic        pk_last;
  logic [31:0] pk_word;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  sum_q;
  logic [7:0]  csum;
  assign csum = sum_q + s_data;
`endif

  // Gated by reset so the stream sees no ready while reset is held.
  assign s_ready = reset &&
    (state inside {IDLE, HDR_HI, DATA, CHK});
  assign accept  = s_valid && s_ready;
  assign hdr     = {s_data, n_words[7:0]};
  assign waiting = state inside {HDR_HI, DATA, CHK};
  assign tout    = (tcnt + 32'd1) == 32'(TIMEOUT_CYC);

  assign pk_push    = accept && (state == DATA);
  assign pk_consume = (state == IDLE) || (state == WRITE);

  rv_mc_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .push      (pk_push),
    .din       (s_data),
    .consume   (pk_consume),
    .word      (pk_word),
    .word_full (pk_full),
    .last      (pk_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    err_n   = err_q;
    unique case (state)
      IDLE: begin
        if (accept) state_n = HDR_HI;
      end
      HDR_HI: begin
        if (accept) begin
          if (hdr == 16'd0) begin
            state_n = FIN_STATE;
          end else if (32'(hdr) > 32'(MAX_WORDS)) begin
            state_n = ERROR;
            err_n   = ERR_LEN;
          end else begin
            state_n = DATA;
          end
        end else if (tout) begin
          state_n = ERROR;
          err_n   = ERR_TIMEOUT;
        end
      end
      DATA: begin
        if (accept) begin
          if (pk_last) state_n = WRITE;
        end else if (tout) begin
          state_n = ERROR;
          err_n   = ERR_TIMEOUT;
        end
      end
      WRITE: begin
        if (idx + 16'd1 == n_words) state_n = FIN_STATE;
        else                        state_n = DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          if (csum == 8'd0) begin
            state_n = DONE;
          end else begin
            state_n = ERROR;
            err_n   = ERR_CSUM;
          end
        end else if (tout) begin
          state_n = ERROR;
          err_n   = ERR_TIMEOUT;
        end
      end
`endif
      DONE: begin
        if (load_req) state_n = IDLE;
      end
      ERROR: begin
        if (load_req) begin
          state_n = IDLE;
          err_n   = ERR_NONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q   <= ERR_NONE;
      n_words <= 16'd0;
      idx     <= 16'd0;
      wl_q    <= 16'd0;
      tcnt    <= 32'd0;
    end else begin
      err_q <= err_n;
      if (accept || !waiting) tcnt <= 32'd0;
      else                    tcnt <= tcnt + 32'd1;
      if (accept && state == IDLE)
        n_words <= {8'd0, s_data};
      if (accept && state == HDR_HI)
        n_words[15:8] <= s_data;
      if (state == WRITE) begin
        idx  <= idx + 16'd1;
        wl_q <= wl_q + 16'd1;
      end
      if (load_req && (state inside {DONE, ERROR})) begin
        idx  <= 16'd0;
        wl_q <= 16'd0;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Sum restarts with the first header byte of each load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_q <= 8'd0;
    end else if (state == IDLE) begin
      sum_q <= accept ? s_data : 8'd0;
    end else if (accept && (state inside {HDR_HI, DATA})) begin
      sum_q <= csum;
    end
  end
`endif

  assign mem_we       = (state == WRITE) && pk_full;
  assign mem_addr     = BASE_ADDR + {14'd0, idx, 2'b00};
  assign mem_wdata    = pk_word;
  assign core_rst     = (state != DONE);
  assign busy         = state inside {HDR_HI, DATA, WRITE, CHK};
  assign done         = (state == DONE);
  assign error        = (state == ERROR);
  assign err_code     = err_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_rv_mc_boot_loader.sv
// tb_rv_mc_boot_loader: directed and randomized image loads
// against a word-level model of the loader.
module tb_rv_mc_boot_loader;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int MAXW = 1024;
  localparam int TOUT = 64;
`ifdef LOADER_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  logic        clk;
  logic        reset;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        load_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [15:0] words_loaded;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  s1[$] = '{8'h93, 8'h00, 8'h50, 8'h00,
                         8'h13, 8'h01, 8'hA0, 8'h00};
  logic [7:0]  empty_q[$];
  logic [7:0]  rd[$];

  rv_mc_boot_loader #(
    .BASE_ADDR   (BASE),
    .MAX_WORDS   (MAXW),
    .TIMEOUT_CYC (TOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .load_req     (load_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_rst     (core_rst),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_code     (err_code),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic req);
    int k;
    k = 0;
    @(negedge clk);
    s_valid  = 1'b1;
    s_data   = b;
    load_req = req;
    while (s_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) chk("send_stall", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1;
    s_valid  = 1'b0;
    load_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    s_valid  = 1'b0;
    load_req = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, BASE);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_err_code", {30'd0, err_code}, 32'd0);
    chk("rst_words", {16'd0, words_loaded}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_rel_ready", {31'd0, s_ready}, 32'd1);
  endtask

  task automatic pulse_req();
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    chk("req_core_rst", {31'd0, core_rst}, 32'd1);
    chk("req_done", {31'd0, done}, 32'd0);
    chk("req_error", {31'd0, error}, 32'd0);
    chk("req_err_code", {30'd0, err_code}, 32'd0);
    chk("req_words", {16'd0, words_loaded}, 32'd0);
    chk("req_ready", {31'd0, s_ready}, 32'd1);
  endtask

  // Model: word i of the image is bytes 4i..4i+3, little-endian,
  // written to BASE + 4i; the core is released once all are in.
  task automatic load_and_check(input string tag,
                                input logic [7:0] d[$],
                                input int gap_fix,
                                input int gap_max,
                                input int exp_lat);
    int n;
    int t0;
    int k;
    logic [7:0]  sum;
    logic [31:0] w;
    n = d.size() / 4;
    wr_addr_q.delete();
    wr_data_q.delete();
    send(n[7:0], 1'b0);
    send(n[15:8], 1'b0);
    sum = n[7:0] + n[15:8];
    t0 = cyc;
    foreach (d[i]) begin
      if (gap_fix > 0) idle(gap_fix);
      else if (gap_max > 0) idle(int'($urandom_range(gap_max, 0)));
      send(d[i], 1'($urandom_range(1, 0)));
      sum = sum + d[i];
    end
    if (CSUM != 0) send(8'd0 - sum, 1'b0);
    k = 0;
    while (core_rst !== 1'b0 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (exp_lat >= 0) chk({tag, "_lat"}, cyc - t0, exp_lat);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_core_rst"}, {31'd0, core_rst}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_ready"}, {31'd0, s_ready}, 32'd0);
    chk({tag, "_words"}, {16'd0, words_loaded}, n);
    chk({tag, "_wr_cnt"}, wr_addr_q.size(), n);
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      w = {d[4*i+3], d[4*i+2], d[4*i+1], d[4*i]};
      chk({tag, "_addr"}, wr_addr_q[i], BASE + 32'(4 * i));
      chk({tag, "_data"}, wr_data_q[i], w);
    end
  endtask

  initial begin
    int n;
    reset    = 1'b0;
    s_valid  = 1'b0;
    s_data   = 8'd0;
    load_req = 1'b0;
    do_reset();

    load_and_check("s1", s1, 0, 0, 10 + CSUM);
    pulse_req();

    load_and_check("n0", empty_q, 0, 0, CSUM);
    chk("n0_no_we", wr_addr_q.size(), 0);
    pulse_req();

    wr_addr_q.delete();
    send(8'h01, 1'b0);
    send(8'h04, 1'b0);
    chk("len_error", {31'd0, error}, 32'd1);
    chk("len_code", {30'd0, err_code}, 32'd1);
    chk("len_core_rst", {31'd0, core_rst}, 32'd1);
    chk("len_busy", {31'd0, busy}, 32'd0);
    chk("len_ready", {31'd0, s_ready}, 32'd0);
    chk("len_no_we", wr_addr_q.size(), 0);
    pulse_req();

    idle(TOUT + 10);
    chk("idle_no_tout", {31'd0, error}, 32'd0);
    chk("idle_ready", {31'd0, s_ready}, 32'd1);

    wr_addr_q.delete();
    send(8'h02, 1'b0);
    send(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0);
    idle(TOUT - 1);
    chk("tout_early", {31'd0, error}, 32'd0);
    chk("tout_busy", {31'd0, busy}, 32'd1);
    idle(1);
    chk("tout_error", {31'd0, error}, 32'd1);
    chk("tout_code", {30'd0, err_code}, 32'd2);
    chk("tout_core_rst", {31'd0, core_rst}, 32'd1);
    chk("tout_no_we", wr_addr_q.size(), 0);
    pulse_req();

    rd.delete();
    for (int i = 0; i < 4; i++) rd.push_back(8'($urandom));
    load_and_check("gap", rd, TOUT - 1, 0, -1);
    pulse_req();

    send(8'h00, 1'b0);
    send(8'h04, 1'b0);
    chk("max_busy", {31'd0, busy}, 32'd1);
    chk("max_error", {31'd0, error}, 32'd0);
    chk("max_ready", {31'd0, s_ready}, 32'd1);
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0);
    do_reset();
    load_and_check("s1_again", s1, 0, 0, 10 + CSUM);
    pulse_req();

`ifdef LOADER_CHECKSUM_EN
    wr_addr_q.delete();
    wr_data_q.delete();
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    send(8'hF5, 1'b0);
    chk("csum_ok_done", {31'd0, done}, 32'd1);
    chk("csum_ok_wr", wr_data_q.size(), 1);
    pulse_req();
    wr_data_q.delete();
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    send(8'hF4, 1'b0);
    chk("csum_bad_error", {31'd0, error}, 32'd1);
    chk("csum_bad_code", {30'd0, err_code}, 32'd3);
    chk("csum_bad_wr", wr_data_q.size(), 1);
    if (wr_data_q.size() > 0)
      chk("csum_bad_data", wr_data_q[0], 32'h0403_0201);
    pulse_req();
`endif

    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(5, 1));
      rd.delete();
      for (int i = 0; i < 4 * n; i++) rd.push_back(8'($urandom));
      load_and_check("rnd", rd, 0, 3, -1);
      pulse_req();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
